// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with busy scoreboard; optional bypass via REGFILE_BYPASS_EN
module regfile_mp #(
  parameter int W        = 32,
  parameter int DEPTH    = 32,
  parameter int NR       = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NR*AW-1:0]  i_rd_addr,
  output logic [NR*W-1:0]   o_rd_data,
  output logic [NR-1:0]     o_rd_busy,
  input  logic [1:0]        i_wr_en,
  input  logic [2*AW-1:0]   i_wr_addr,
  input  logic [2*W-1:0]    i_wr_data,
  input  logic              i_iss_en,
  input  logic [AW-1:0]     i_iss_addr,
  output logic              o_any_busy
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [AW-1:0]    w_wa [2];
  logic [W-1:0]     w_wd [2];
  logic [1:0]       w_wok;
  logic             w_iss_ok;
  logic [AW-1:0]    w_ra [NR];

  // An address is storable when it is in range and is not the hard-wired zero register
  function automatic logic f_valid(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Unpack write/issue buses and qualify each request against the address space
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_wa[p]  = i_wr_addr[p*AW +: AW];
      w_wd[p]  = i_wr_data[p*W +: W];
      w_wok[p] = i_wr_en[p] && f_valid(w_wa[p]);
    end
    w_iss_ok = i_iss_en && f_valid(i_iss_addr);
  end

  // Unpack read addresses
  always_comb begin
    for (int k = 0; k < NR; k++) begin
      w_ra[k] = i_rd_addr[k*AW +: AW];
    end
  end

  // Next busy vector: retiring writes clear, a new issue sets and overrides a same-cycle clear
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wok[0] && (w_wa[0] == AW'(i))) w_busy_nxt[i] = 1'b0;
      if (w_wok[1] && (w_wa[1] == AW'(i))) w_busy_nxt[i] = 1'b0;
      if (w_iss_ok && (i_iss_addr == AW'(i))) w_busy_nxt[i] = 1'b1;
    end
  end

  // Storage update: port 1 is applied last so it wins an address collision
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wok[0] && (w_wa[0] == AW'(i))) r_mem[i] <= w_wd[0];
        if (w_wok[1] && (w_wa[1] == AW'(i))) r_mem[i] <= w_wd[1];
      end
      r_busy <= w_busy_nxt;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [NR-1:0] w_hit;
`endif

  // Read ports: stored state, optionally overlaid with this cycle's accepted writes
  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
`ifdef REGFILE_BYPASS_EN
    w_hit = '0;
`endif
    for (int k = 0; k < NR; k++) begin
      if (f_valid(w_ra[k])) begin
        o_rd_data[k*W +: W] = r_mem[w_ra[k]];
        o_rd_busy[k]        = r_busy[w_ra[k]];
      end
`ifdef REGFILE_BYPASS_EN
      if (!i_reset) begin
        for (int p = 0; p < 2; p++) begin
          if (w_wok[p] && (w_wa[p] == w_ra[k])) begin
            o_rd_data[k*W +: W] = w_wd[p];
            o_rd_busy[k]        = 1'b0;
            w_hit[k]            = 1'b1;
          end
        end
        if (w_hit[k] && w_iss_ok && (i_iss_addr == w_ra[k])) o_rd_busy[k] = 1'b1;
      end
`endif
    end
  end

  // Aggregate pending-writeback flag from registered state only
  assign o_any_busy = |r_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - table-driven bench for regfile_mp (default and NR=4/DEPTH=16/W=16/ZERO_REG=0 builds)
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        any_busy;

  logic [15:0] rd_addr4;
  logic [63:0] rd_data4;
  logic [3:0]  rd_busy4;
  logic [1:0]  wr_en4;
  logic [7:0]  wr_addr4;
  logic [31:0] wr_data4;
  logic        iss_en4;
  logic [3:0]  iss_addr4;
  logic        any_busy4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .i_clk(clk), .i_reset(reset), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_rd_busy(rd_busy), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_iss_en(iss_en), .i_iss_addr(iss_addr), .o_any_busy(any_busy)
  );

  regfile_mp #(.W(16), .DEPTH(16), .NR(4), .ZERO_REG(0)) u_dut4 (
    .i_clk(clk), .i_reset(reset), .i_rd_addr(rd_addr4), .o_rd_data(rd_data4),
    .o_rd_busy(rd_busy4), .i_wr_en(wr_en4), .i_wr_addr(wr_addr4), .i_wr_data(wr_data4),
    .i_iss_en(iss_en4), .i_iss_addr(iss_addr4), .o_any_busy(any_busy4)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic [1:0]  eb;
    logic        ea;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1, logic ie, logic [4:0] ia,
                              logic [4:0] ra0, logic [4:0] ra1, logic [31:0] ed0,
                              logic [31:0] ed1, logic [1:0] eb, logic ea);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ie = ie; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1;
    v.ed0 = ed0; v.ed1 = ed1; v.eb = eb; v.ea = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
    wr_en4 = '0; wr_addr4 = '0; wr_data4 = '0; iss_en4 = 1'b0; iss_addr4 = '0; rd_addr4 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic [31:0] ed0, input logic [31:0] ed1,
                          input logic [1:0] eb, input logic ea);
    chk({tag, ".d0"}, rd_data[31:0], ed0);
    chk({tag, ".d1"}, rd_data[63:32], ed1);
    chk({tag, ".b0"}, {31'd0, rd_busy[0]}, {31'd0, eb[0]});
    chk({tag, ".b1"}, {31'd0, rd_busy[1]}, {31'd0, eb[1]});
    chk({tag, ".any"}, {31'd0, any_busy}, {31'd0, ea});
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // reset state
    rd_addr = {5'd6, 5'd5};
    #4 chk_main("rst_state", 32'h0, 32'h0, 2'b00, 1'b0);
    chk("rst_any4", {31'd0, any_busy4}, 32'd0);
    tick();

    // preload r5 and its busy bit, then reset with writes pending
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    iss_en = 1'b1; iss_addr = 5'd5;
    tick();
    idle(); rd_addr = {5'd6, 5'd5};
    #4 chk_main("preload", 32'hDEADBEEF, 32'h0, 2'b01, 1'b1);
    tick();
    reset = 1'b1;
    wr_en = 2'b11; wr_addr = {5'd6, 5'd6}; wr_data = {32'hCAFEF00D, 32'h01234567};
    iss_en = 1'b1; iss_addr = 5'd6;
    tick();
    reset = 1'b0; idle(); rd_addr = {5'd6, 5'd5};
    #4 chk_main("post_rst", 32'h0, 32'h0, 2'b00, 1'b0);
    tick();

    // table: reads never hit an address written in the same cycle, so bypass does not matter
    tbl[0]  = mk(2'b00, 0, 0, 0, 0, 1, 3,  5, 6, 32'h0, 32'h0, 2'b00, 0);
    tbl[1]  = mk(2'b00, 0, 0, 0, 0, 0, 0,  3, 0, 32'h0, 32'h0, 2'b01, 1);
    tbl[2]  = mk(2'b11, 7, 32'h11111111, 7, 32'h22222222, 0, 0, 3, 0, 32'h0, 32'h0, 2'b01, 1);
    tbl[3]  = mk(2'b00, 0, 0, 0, 0, 0, 0,  7, 3, 32'h22222222, 32'h0, 2'b10, 1);
    tbl[4]  = mk(2'b01, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 7, 3, 32'h22222222, 32'h0, 2'b10, 1);
    tbl[5]  = mk(2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0, 32'h0, 2'b00, 1);
    tbl[6]  = mk(2'b01, 3, 32'hA5, 0, 0, 0, 0, 7, 0, 32'h22222222, 32'h0, 2'b00, 1);
    tbl[7]  = mk(2'b00, 0, 0, 0, 0, 0, 0,  3, 7, 32'hA5, 32'h22222222, 2'b00, 0);
    tbl[8]  = mk(2'b10, 0, 0, 3, 32'h5A, 1, 3, 7, 0, 32'h22222222, 32'h0, 2'b00, 0);
    tbl[9]  = mk(2'b00, 0, 0, 0, 0, 0, 0,  3, 7, 32'h5A, 32'h22222222, 2'b01, 1);
    tbl[10] = mk(2'b11, 10, 32'hAAAA, 11, 32'hBBBB, 0, 0, 3, 7, 32'h5A, 32'h22222222, 2'b01, 1);
    tbl[11] = mk(2'b00, 0, 0, 0, 0, 0, 0, 10, 11, 32'hAAAA, 32'hBBBB, 2'b00, 1);
    tbl[12] = mk(2'b01, 3, 32'h1, 0, 0, 1, 3, 10, 11, 32'hAAAA, 32'hBBBB, 2'b00, 1);
    tbl[13] = mk(2'b00, 0, 0, 0, 0, 0, 0,  3, 11, 32'h1, 32'hBBBB, 2'b01, 1);
    tbl[14] = mk(2'b01, 3, 32'h2, 0, 0, 0, 0, 10, 11, 32'hAAAA, 32'hBBBB, 2'b00, 1);
    tbl[15] = mk(2'b00, 0, 0, 0, 0, 0, 0,  3, 10, 32'h2, 32'hAAAA, 2'b00, 0);

    for (int i = 0; i < 16; i++) begin
      wr_en    = tbl[i].we;
      wr_addr  = {tbl[i].wa1, tbl[i].wa0};
      wr_data  = {tbl[i].wd1, tbl[i].wd0};
      iss_en   = tbl[i].ie;
      iss_addr = tbl[i].ia;
      rd_addr  = {tbl[i].ra1, tbl[i].ra0};
      #4 chk_main($sformatf("vec%0d", i), tbl[i].ed0, tbl[i].ed1, tbl[i].eb, tbl[i].ea);
      tick();
    end

    // bypass: r9 pending, then written while being read
    idle(); iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h12345678};
    rd_addr = {5'd9, 5'd9};
`ifdef REGFILE_BYPASS_EN
    #4 chk_main("bypass", 32'h12345678, 32'h12345678, 2'b00, 1'b1);
`else
    #4 chk_main("no_bypass", 32'h0, 32'h0, 2'b11, 1'b1);
`endif
    tick();
    idle(); rd_addr = {5'd0, 5'd9};
    #4 chk_main("after_wr9", 32'h12345678, 32'h0, 2'b00, 1'b0);
    tick();

    // wide-read instance: r0 is an ordinary register here
    idle(); wr_en4 = 2'b11; wr_addr4 = {4'd1, 4'd0}; wr_data4 = {16'h1111, 16'hBEEF};
    tick();
    idle(); wr_en4 = 2'b11; wr_addr4 = {4'd3, 4'd2}; wr_data4 = {16'h3333, 16'h2222};
    iss_en4 = 1'b1; iss_addr4 = 4'd15;
    tick();
    idle(); rd_addr4 = {4'd3, 4'd2, 4'd1, 4'd0};
    #4;
    chk("p4.r0", {16'h0, rd_data4[15:0]},  32'hBEEF);
    chk("p4.r1", {16'h0, rd_data4[31:16]}, 32'h1111);
    chk("p4.r2", {16'h0, rd_data4[47:32]}, 32'h2222);
    chk("p4.r3", {16'h0, rd_data4[63:48]}, 32'h3333);
    chk("p4.busy", {28'h0, rd_busy4}, 32'h0);
    chk("p4.any", {31'h0, any_busy4}, 32'h1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
